// File: rtl/plab5_mcore_debug_arbiter_checker.sv
// Multi-port debug arbiter: round-robin grant, security-domain check against the DMA
// controller, DMA request/timeout handling and saturating deny/timeout counters.
module plab5_mcore_debug_arbiter_checker #(
  parameter int p_num_ports      = 4,
  parameter int p_addr_nbits     = 32,
  parameter int p_data_nbits     = 32,
  parameter int p_timeout_cycles = 16,
  parameter int p_cnt_nbits      = 8
)(
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [p_num_ports-1:0]                debug_val,
  input  logic [p_num_ports-1:0]                debug_domain,
  input  logic [p_num_ports*p_addr_nbits-1:0]   debug_src_addr,
  input  logic [p_num_ports*p_addr_nbits-1:0]   debug_dest_addr,
  input  logic [p_num_ports-1:0]                debug_inst,
  output logic [p_num_ports-1:0]                debug_ack,
  output logic [1:0]                            debug_err,
  output logic [p_data_nbits-1:0]               debug_data,
  output logic                                  debug_resp_domain,
  input  logic                                  dma_domain,
  input  logic                                  dma_ack,
  output logic                                  dma_db_val,
  output logic [p_addr_nbits-1:0]               dma_db_src_addr,
  output logic [p_addr_nbits-1:0]               dma_db_dest_addr,
  output logic                                  dma_db_inst,
  input  logic [p_data_nbits-1:0]               dma_db_debug_data,
  output logic [p_cnt_nbits-1:0]                deny_count,
  output logic [p_cnt_nbits-1:0]                timeout_count
);

  localparam int ptr_nbits = (p_num_ports > 1) ? $clog2(p_num_ports) : 1;
  localparam int tmo_nbits = (p_timeout_cycles > 1) ? $clog2(p_timeout_cycles) : 1;

  typedef enum logic [2:0] {IDLE, CHECK, REQ, WAIT, RESP} state_t;

  state_t                  state, state_next;
  logic [ptr_nbits-1:0]    rr_ptr, gnt, arb_idx, cand;
  logic                    arb_any;
  logic                    lat_domain, lat_inst;
  logic [p_addr_nbits-1:0] lat_src, lat_dest;
  logic [tmo_nbits-1:0]    timeout_ctr;
  logic [1:0]              err_reg;
  logic [p_data_nbits-1:0] data_reg;
  logic                    domain_match, deny, dma_done, tmo_done;

  assign domain_match = (lat_domain == dma_domain);
  assign deny         = (lat_domain < dma_domain);
  assign dma_done     = dma_ack && domain_match;
  assign tmo_done     = (timeout_ctr == tmo_nbits'(p_timeout_cycles - 1));

  // First requesting port at or above rr_ptr, wrapping around.
  always_comb begin
    arb_any = 1'b0;
    arb_idx = '0;
    cand    = '0;
    for (int k = 0; k < p_num_ports; k++) begin
      cand = ptr_nbits'((int'(rr_ptr) + k) % p_num_ports);
      if (!arb_any && debug_val[cand]) begin
        arb_any = 1'b1;
        arb_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (arb_any) state_next = CHECK;
      CHECK:   state_next = deny ? RESP : REQ;
      REQ:     state_next = WAIT;
      WAIT:    if (dma_done || tmo_done) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr        <= '0;
      gnt           <= '0;
      lat_domain    <= 1'b0;
      lat_inst      <= 1'b0;
      lat_src       <= '0;
      lat_dest      <= '0;
      timeout_ctr   <= '0;
      err_reg       <= 2'b00;
      data_reg      <= '0;
      deny_count    <= '0;
      timeout_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (arb_any) begin
            gnt        <= arb_idx;
            lat_domain <= debug_domain[arb_idx];
            lat_inst   <= debug_inst[arb_idx];
            lat_src    <= debug_src_addr[int'(arb_idx)*p_addr_nbits +: p_addr_nbits];
            lat_dest   <= debug_dest_addr[int'(arb_idx)*p_addr_nbits +: p_addr_nbits];
          end
        end
        CHECK: begin
          if (deny) begin
            err_reg  <= 2'b01;
            data_reg <= '0;
            if (deny_count != '1) deny_count <= deny_count + 1'b1;
          end
        end
        REQ: timeout_ctr <= '0;
        WAIT: begin
          if (dma_done) begin
            err_reg  <= 2'b00;
            data_reg <= dma_db_debug_data;
          end else if (tmo_done) begin
            err_reg  <= 2'b10;
            data_reg <= '0;
            if (timeout_count != '1) timeout_count <= timeout_count + 1'b1;
          end else begin
            timeout_ctr <= timeout_ctr + 1'b1;
          end
        end
        RESP: rr_ptr <= (gnt == ptr_nbits'(p_num_ports - 1)) ? '0 : gnt + 1'b1;
        default: ;
      endcase
    end
  end

  // All outputs derive from registers that reset asynchronously, so reset clears them at once.
  always_comb begin
    for (int i = 0; i < p_num_ports; i++) begin
      debug_ack[i] = (state == RESP) && (gnt == ptr_nbits'(i));
    end
    debug_err        = (state == RESP) ? err_reg : 2'b00;
    debug_data       = ((state == RESP) && (err_reg == 2'b00)) ? data_reg : '0;
    dma_db_val       = (state == REQ) && domain_match;
    dma_db_src_addr  = (state == REQ) ? lat_src : '0;
    dma_db_dest_addr = (state == REQ) ? lat_dest : '0;
    dma_db_inst      = (state == REQ) && lat_inst;
  end

  assign debug_resp_domain = lat_domain;

endmodule
